instr_mem_loader: RTL and testbench

Program loader that writes the instruction memory the MIPS fetch stage reads. It receives a framed byte stream from the board UART receiver and assembles big-endian 32-bit words. Each word is written at consecutive word-aligned byte addresses starting at 0. The CPU is held in reset until a frame passes its checksum.

---
 rtl/loader_pkg.sv | 13 +
 rtl/byte_word_packer.sv | 27 ++
 rtl/instr_mem_loader.sv | 155 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared encodings for the instruction-memory loader: FSM states and frame constants.
package loader_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;
endpackage

// File: rtl/byte_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream; flags the 4th byte of each word.
module byte_word_packer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);
  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_valid) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  // The word is presented in the same cycle as its last byte so the caller can register it directly.
  assign o_word       = {r_shift, i_byte};
  assign o_word_ready = i_valid && (r_cnt == 2'd3);
endmodule

// File: rtl/instr_mem_loader.sv
// Framed UART program loader: writes instruction memory and holds the CPU until a frame checks out.
// Handshake: rx_valid is a one-cycle strobe with no backpressure; every strobed byte is consumed that cycle.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH      = 64,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output state_t                dbg_state
);
  localparam int IDXW = $clog2(MEM_DEPTH) + 1;
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]    MAX_LEN = 9'(MEM_DEPTH);

  state_t                r_state;
  logic [IDXW-1:0]       r_len;
  logic [IDXW-1:0]       r_idx;
  logic [7:0]            r_csum;
  logic [TW-1:0]         r_timer;
  logic                  r_mem_we;
  logic [31:0]           r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_cpu_hold;
  logic                  r_done;
  logic                  r_error;

  logic                  w_timing;
  logic                  w_timeout;
  logic                  w_len_bad;
  logic                  w_is_header;
  logic [IDXW-1:0]       w_idx_next;
  logic [31:0]           w_word;
  logic                  w_word_ready;

  byte_word_packer u_packer (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_clear      (r_state == ST_LEN),
    .i_valid      (rx_valid && (r_state == ST_DATA)),
    .i_byte       (rx_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  assign w_timing    = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CHECK);
  // A byte in the expiry cycle wins over the timeout.
  assign w_timeout   = w_timing && !rx_valid && (r_timer == TO_LAST);
  assign w_len_bad   = (rx_data == 8'd0) || ({1'b0, rx_data} > MAX_LEN);
  assign w_is_header = rx_valid && (rx_data == FRAME_HEADER);
  assign w_idx_next  = r_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_idx       <= '0;
      r_csum      <= '0;
      r_timer     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (rx_valid || w_timeout || !w_timing) r_timer <= '0;
      else                                    r_timer <= r_timer + 1'b1;

      case (r_state)
        ST_IDLE: if (w_is_header) r_state <= ST_LEN;
        ST_LEN: begin
          if (w_timeout) begin
            r_state <= ST_ERR;
            r_error <= 1'b1;
          end else if (rx_valid) begin
            if (w_len_bad) begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end else begin
              r_len   <= rx_data[IDXW-1:0];
              r_idx   <= '0;
              r_csum  <= '0;
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_timeout) begin
            r_state <= ST_ERR;
            r_error <= 1'b1;
          end else if (rx_valid) begin
            r_csum <= r_csum + rx_data;
            if (w_word_ready) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {{(30 - IDXW){1'b0}}, r_idx, 2'b00};
              r_mem_wdata <= w_word;
              r_idx       <= w_idx_next;
              if (w_idx_next == r_len) r_state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (w_timeout) begin
            r_state <= ST_ERR;
            r_error <= 1'b1;
          end else if (rx_valid) begin
            if (rx_data == r_csum) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (w_is_header) begin
            r_state    <= ST_LEN;
            r_done     <= 1'b0;
            r_cpu_hold <= 1'b1;
          end
        end
        ST_ERR: begin
          if (w_is_header) begin
            r_state <= ST_LEN;
            r_error <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign done      = r_done;
  assign error     = r_error;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a write scoreboard plus status checks after each frame.
module tb_instr_mem_loader;
  import loader_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  logic [31:0] wbuf[64];

  instr_mem_loader #(
    .DATA_WIDTH     (32),
    .MEM_DEPTH      (64),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every mem_we pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        check("mem_write", {mem_addr, mem_wdata}, exp_e);
      end
    end
  end

  // Driver tasks; each returns 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] addr);
    exp_q.push_back({addr, w});
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic send_frame(input int n);
    logic [7:0] cs;
    cs = 8'h00;
    send_byte(FRAME_HEADER);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      cs = cs + wbuf[i][31:24] + wbuf[i][23:16] + wbuf[i][15:8] + wbuf[i][7:0];
      send_word(wbuf[i], 32'(i * 4));
    end
    send_byte(cs);
  endtask

  task automatic check_status(input string name, input logic e_done, input logic e_err, input logic e_hold);
    check({name, "_done"}, 64'(done), 64'(e_done));
    check({name, "_error"}, 64'(error), 64'(e_err));
    check({name, "_hold"}, 64'(cpu_hold), 64'(e_hold));
    check({name, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_we"}, 64'(mem_we), 64'd0);
    check({name, "_addr"}, 64'(mem_addr), 64'd0);
    check({name, "_wdata"}, 64'(mem_wdata), 64'd0);
    check({name, "_hold"}, 64'(cpu_hold), 64'd1);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_error"}, 64'(error), 64'd0);
    check({name, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    reset    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    reset = 1'b1;
    idle(2);

    // Nominal two-word load, small gaps between words
    send_byte(8'hA5);
    send_byte(8'h02);
    send_word(32'h20080005, 32'h00);
    idle(1);
    send_word(32'h00000008, 32'h04);
    idle(2);
    send_byte(8'h35);
    check_status("nominal", 1'b1, 1'b0, 1'b0);

    // Bad checksum; header in DONE re-holds the CPU immediately
    send_byte(8'hA5);
    check("rehold_hold", 64'(cpu_hold), 64'd1);
    check("rehold_done", 64'(done), 64'd0);
    send_byte(8'h02);
    send_word(32'h20080005, 32'h00);
    send_word(32'h00000008, 32'h04);
    send_byte(8'h36);
    check_status("bad_cs", 1'b0, 1'b1, 1'b1);

    // Length limits
    send_byte(8'hA5);
    check("err_clear_on_header", 64'(error), 64'd0);
    send_byte(8'h00);
    check_status("len_zero", 1'b0, 1'b1, 1'b1);
    send_byte(8'hA5);
    send_byte(8'h41);
    check_status("len_65", 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 64; i++) wbuf[i] = {8'(i), 8'(~i), 8'(i * 3), 8'h5A};
    send_frame(64);
    check_status("len_64", 1'b1, 1'b0, 1'b0);
    check("len_64_last_addr", 64'(mem_addr), 64'hFC);

    // Back-to-back frame with 0xA5 inside the payload
    send_byte(8'hA5);
    send_byte(8'h02);
    send_word(32'hA5000001, 32'h00);
    send_word(32'h12A5A534, 32'h04);
    send_byte(8'h36);
    check_status("b2b", 1'b1, 1'b0, 1'b0);

    // Timeout after 3 payload bytes
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h08);
    send_byte(8'h00);
    idle(10);
    check("timeout_early_error", 64'(error), 64'd0);
    idle(10);
    check_status("timeout", 1'b0, 1'b1, 1'b1);
    wbuf[0] = 32'hDEADBEEF;
    wbuf[1] = 32'h01234567;
    wbuf[2] = 32'hFFFFFFFF;
    send_frame(3);
    check_status("after_timeout", 1'b1, 1'b0, 1'b0);

    // Reset pulse mid-DATA, stray bytes, then a clean load
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b0;
    idle(1);
    check_reset_outputs("mid_reset");
    reset = 1'b1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h00);
    check("stray_state", 64'(dbg_state), 64'(ST_IDLE));
    send_byte(8'hA5);
    send_byte(8'h02);
    send_word(32'h20080005, 32'h00);
    send_word(32'h00000008, 32'h04);
    send_byte(8'h35);
    check_status("post_reset", 1'b1, 1'b0, 1'b0);

    idle(4);
    check("final_pending_writes", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
